// File: rtl/mure_pkg.sv
// Shared types and widths for the buffered multiple-retirement serializer.
// Holds the per-entry trace record and the occupancy-counter width helper.
package mure_pkg;

    localparam int ITYPE_LEN = 3;
    localparam int CAUSE_LEN = 5;
    localparam int XLEN      = 32;
    localparam int PRIV_LEN  = 2;

    typedef struct packed {
        logic                 ilastsize;
        logic [ITYPE_LEN-1:0] itype;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
        logic [XLEN-1:0]      iaddr;
    } mure_entry_s;

    // Occupancy must reach Depth itself, hence the +1.
    function automatic int mure_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mure_compactor.sv
// Packs valid retirement slots into the low indices, lowest slot first, and counts them.
// Purely combinational; no state, no backpressure.
// Unused output positions are driven to zero.
module mure_compactor
    import mure_pkg::*;
#(
    parameter int NrRetiredInstr = 2,
    localparam int PW            = $clog2(NrRetiredInstr + 1)
) (
    input  logic        [NrRetiredInstr-1:0] valid_i,
    input  mure_entry_s [NrRetiredInstr-1:0] entry_i,
    output mure_entry_s [NrRetiredInstr-1:0] entry_o,
    output logic        [PW-1:0]             cnt_o
);

    always_comb begin
        int w_pre;
        entry_o = '0;
        w_pre   = 0;
        for (int k = 0; k < NrRetiredInstr; k++) begin
            if (valid_i[k]) begin
                for (int j = 0; j < NrRetiredInstr; j++) begin
                    if (w_pre == j) entry_o[j] = entry_i[k];
                end
                w_pre = w_pre + 1;
            end
        end
        cnt_o = PW'(w_pre);
    end

endmodule

// File: rtl/multiple_retirement_buffered.sv
// Compacts up to NrRetiredInstr retirements per cycle into a FIFO; drains NrOutPorts per cycle.
// Latency 1 cycle (0 for the head entries when MURE_BYPASS_EN is defined and the FIFO is empty).
// Batches that do not fit the start-of-cycle free space are dropped whole and flagged sticky.
module multiple_retirement_buffered
    import mure_pkg::*;
#(
    parameter int NrRetiredInstr = 2,
    parameter int NrOutPorts     = 1,
    parameter int Depth          = 8,
    localparam int CntW          = mure_cnt_w(Depth),
    localparam int PtrW          = $clog2(Depth),
    localparam int PW            = $clog2(NrRetiredInstr + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrRetiredInstr-1:0]                iretire_i,
    input  logic [NrRetiredInstr-1:0]                ilastsize_i,
    input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i,
    input  logic [CAUSE_LEN-1:0]                     cause_i,
    input  logic [XLEN-1:0]                          tval_i,
    input  logic [PRIV_LEN-1:0]                      priv_i,
    input  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i,
    input  logic                                     ready_i,
    output logic                                     ready_o,
    output logic [NrOutPorts-1:0]                    iretire_o,
    output logic [NrOutPorts-1:0]                    ilastsize_o,
    output logic [NrOutPorts-1:0][ITYPE_LEN-1:0]     itype_o,
    output logic [NrOutPorts-1:0][CAUSE_LEN-1:0]     cause_o,
    output logic [NrOutPorts-1:0][XLEN-1:0]          tval_o,
    output logic [NrOutPorts-1:0][PRIV_LEN-1:0]      priv_o,
    output logic [NrOutPorts-1:0][XLEN-1:0]          iaddr_o,
    output logic [CntW-1:0]                          count_o,
    output logic                                     overflow_o
);

    mure_entry_s [Depth-1:0]          r_mem;
    logic        [PtrW-1:0]           r_rd_ptr;
    logic        [PtrW-1:0]           r_wr_ptr;
    logic        [CntW-1:0]           r_count;
    logic                             r_overflow;

    mure_entry_s [NrRetiredInstr-1:0] w_in;
    mure_entry_s [NrRetiredInstr-1:0] w_comp;
    mure_entry_s [NrRetiredInstr-1:0] w_push_ent;
    mure_entry_s [NrOutPorts-1:0]     w_out;
    logic        [NrOutPorts-1:0]     w_out_vld;
    logic        [PW-1:0]             w_p;
    logic        [PW-1:0]             w_byp_n;
    logic        [PW-1:0]             w_push_n;
    logic        [CntW-1:0]           w_pop_n;
    logic                             w_accept;

    always_comb begin
        for (int k = 0; k < NrRetiredInstr; k++) begin
            w_in[k] = '{ilastsize: ilastsize_i[k], itype: itype_i[k], cause: cause_i,
                        tval: tval_i, priv: priv_i, iaddr: iaddr_i[k]};
        end
    end

    mure_compactor #(.NrRetiredInstr(NrRetiredInstr)) u_compactor (
        .valid_i (iretire_i),
        .entry_i (w_in),
        .entry_o (w_comp),
        .cnt_o   (w_p)
    );

    // Free space is judged on the start-of-cycle count; pops in the same cycle give no credit.
    always_comb begin
        w_byp_n = '0;
`ifdef MURE_BYPASS_EN
        if (r_count == '0 && ready_i) begin
            w_byp_n = (int'(w_p) < NrOutPorts) ? w_p : PW'(NrOutPorts);
        end
`endif
        w_accept = int'(w_p) <= (Depth - int'(r_count));
        w_push_n = w_accept ? (w_p - w_byp_n) : '0;
        w_pop_n  = '0;
        if (ready_i) begin
            w_pop_n = (int'(r_count) < NrOutPorts) ? r_count : CntW'(NrOutPorts);
        end
        for (int j = 0; j < NrRetiredInstr; j++) begin
            w_push_ent[j] = '0;
            for (int s = 0; s < NrRetiredInstr; s++) begin
                if (s == j + int'(w_byp_n)) w_push_ent[j] = w_comp[s];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NrRetiredInstr; j++) begin
            if (j < int'(w_push_n)) r_mem[r_wr_ptr + PtrW'(j)] <= w_push_ent[j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PtrW'(w_pop_n);
            r_wr_ptr <= r_wr_ptr + PtrW'(w_push_n);
            r_count  <= r_count + CntW'(w_push_n) - w_pop_n;
            if (!w_accept) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NrOutPorts; k++) begin
            w_out[k]     = '0;
            w_out_vld[k] = 1'b0;
            if (int'(r_count) > k) begin
                w_out_vld[k] = 1'b1;
                w_out[k]     = r_mem[r_rd_ptr + PtrW'(k)];
            end
`ifdef MURE_BYPASS_EN
            if (int'(w_byp_n) > k) begin
                w_out_vld[k] = 1'b1;
                w_out[k]     = w_comp[k];
            end
`endif
            iretire_o[k]   = w_out_vld[k];
            ilastsize_o[k] = w_out[k].ilastsize;
            itype_o[k]     = w_out[k].itype;
            cause_o[k]     = w_out[k].cause;
            tval_o[k]      = w_out[k].tval;
            priv_o[k]      = w_out[k].priv;
            iaddr_o[k]     = w_out[k].iaddr;
        end
    end

    assign ready_o    = (Depth - int'(r_count)) >= NrRetiredInstr;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_multiple_retirement_buffered.sv
// Directed bench for multiple_retirement_buffered with default parameters (2 in, 1 out, depth 8).
module tb_multiple_retirement_buffered;
    import mure_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [1:0]                iretire_i;
    logic [1:0]                ilastsize_i;
    logic [1:0][ITYPE_LEN-1:0] itype_i;
    logic [CAUSE_LEN-1:0]      cause_i;
    logic [XLEN-1:0]           tval_i;
    logic [PRIV_LEN-1:0]       priv_i;
    logic [1:0][XLEN-1:0]      iaddr_i;
    logic                      ready_i;
    logic                      ready_o;
    logic [0:0]                iretire_o;
    logic [0:0]                ilastsize_o;
    logic [0:0][ITYPE_LEN-1:0] itype_o;
    logic [0:0][CAUSE_LEN-1:0] cause_o;
    logic [0:0][XLEN-1:0]      tval_o;
    logic [0:0][PRIV_LEN-1:0]  priv_o;
    logic [0:0][XLEN-1:0]      iaddr_o;
    logic [3:0]                count_o;
    logic                      overflow_o;

    int checks   = 0;
    int failures = 0;

    multiple_retirement_buffered #(.NrRetiredInstr(2), .NrOutPorts(1), .Depth(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .iretire_i   (iretire_i),
        .ilastsize_i (ilastsize_i),
        .itype_i     (itype_i),
        .cause_i     (cause_i),
        .tval_i      (tval_i),
        .priv_i      (priv_i),
        .iaddr_i     (iaddr_i),
        .ready_i     (ready_i),
        .ready_o     (ready_o),
        .iretire_o   (iretire_o),
        .ilastsize_o (ilastsize_o),
        .itype_o     (itype_o),
        .cause_o     (cause_o),
        .tval_o      (tval_o),
        .priv_o      (priv_o),
        .iaddr_o     (iaddr_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        iretire_i   = '0;
        ilastsize_i = '0;
        itype_i     = '0;
        cause_i     = '0;
        tval_i      = '0;
        priv_i      = '0;
        iaddr_i     = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        ready_i = 1'b1;
        rst_ni  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (iretire_o !== 1'b0) begin failures++; $display("FAIL reset_iretire act=%0b exp=0", iretire_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL reset_count act=%0d exp=0", count_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready act=%0b exp=1", ready_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow act=%0b exp=0", overflow_o); end
        checks++; if (iaddr_o[0] !== 32'h0) begin failures++; $display("FAIL reset_iaddr act=%h exp=0", iaddr_o[0]); end
    endtask

    task automatic test_order;
        @(negedge clk_i);
        ready_i    = 1'b1;
        iretire_i  = 2'b11;
        iaddr_i[0] = 32'h1000;
        iaddr_i[1] = 32'h1004;
`ifdef MURE_BYPASS_EN
        #1;
        checks++; if (iaddr_o[0] !== 32'h1000) begin failures++; $display("FAIL order_byp0 act=%h exp=1000", iaddr_o[0]); end
        tick();
        iretire_i = 2'b00;
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL order_byp_count act=%0d exp=1", count_o); end
`else
        tick();
        iretire_i = 2'b00;
        checks++; if (iaddr_o[0] !== 32'h1000 || iretire_o !== 1'b1) begin failures++; $display("FAIL order_first act=%h/%0b exp=1000/1", iaddr_o[0], iretire_o); end
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL order_count act=%0d exp=2", count_o); end
        tick();
`endif
        checks++; if (iaddr_o[0] !== 32'h1004 || iretire_o !== 1'b1) begin failures++; $display("FAIL order_second act=%h/%0b exp=1004/1", iaddr_o[0], iretire_o); end
        tick();
        checks++; if (iretire_o !== 1'b0 || iaddr_o[0] !== 32'h0) begin failures++; $display("FAIL order_empty act=%0b/%h exp=0/0", iretire_o, iaddr_o[0]); end
    endtask

    task automatic test_fields;
        ready_i        = 1'b0;
        iretire_i      = 2'b10;
        iaddr_i[1]     = 32'h2002;
        itype_i[1]     = 3'd1;
        ilastsize_i[1] = 1'b1;
        cause_i        = 5'd2;
        tval_i         = 32'hDEAD;
        priv_i         = 2'd3;
        tick();
        clear_inputs();
        checks++; if (iaddr_o[0] !== 32'h2002) begin failures++; $display("FAIL fields_iaddr act=%h exp=2002", iaddr_o[0]); end
        checks++; if (itype_o[0] !== 3'd1) begin failures++; $display("FAIL fields_itype act=%0d exp=1", itype_o[0]); end
        checks++; if (cause_o[0] !== 5'd2) begin failures++; $display("FAIL fields_cause act=%0d exp=2", cause_o[0]); end
        checks++; if (tval_o[0] !== 32'hDEAD) begin failures++; $display("FAIL fields_tval act=%h exp=dead", tval_o[0]); end
        checks++; if (priv_o[0] !== 2'd3 || ilastsize_o[0] !== 1'b1) begin failures++; $display("FAIL fields_priv_size act=%0d/%0b exp=3/1", priv_o[0], ilastsize_o[0]); end
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL fields_count act=%0d exp=1", count_o); end
        ready_i = 1'b1;
        tick();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL fields_drain act=%0d exp=0", count_o); end
    endtask

    task automatic test_fill_overflow;
        ready_i   = 1'b0;
        iretire_i = 2'b11;
        for (int b = 0; b < 3; b++) begin
            iaddr_i[0] = 32'h100 + 32'(b * 8);
            iaddr_i[1] = 32'h104 + 32'(b * 8);
            tick();
        end
        checks++; if (count_o !== 4'd6) begin failures++; $display("FAIL fill_count6 act=%0d exp=6", count_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready6 act=%0b exp=1", ready_o); end
        checks++; if (iaddr_o[0] !== 32'h100) begin failures++; $display("FAIL fill_head_hold act=%h exp=100", iaddr_o[0]); end
        iaddr_i[0] = 32'h118;
        iaddr_i[1] = 32'h11C;
        tick();
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL fill_count8 act=%0d exp=8", count_o); end
        checks++; if (ready_o !== 1'b0 || overflow_o !== 1'b0) begin failures++; $display("FAIL fill_full_flags act=%0b/%0b exp=0/0", ready_o, overflow_o); end
        iaddr_i[0] = 32'h900;
        iaddr_i[1] = 32'h904;
        tick();
        checks++; if (overflow_o !== 1'b1 || count_o !== 4'd8) begin failures++; $display("FAIL drop_idle act=%0b/%0d exp=1/8", overflow_o, count_o); end
        ready_i    = 1'b1;
        iaddr_i[0] = 32'hA00;
        iaddr_i[1] = 32'hA04;
        tick();
        checks++; if (count_o !== 4'd7 || overflow_o !== 1'b1) begin failures++; $display("FAIL drop_nocredit act=%0d/%0b exp=7/1", count_o, overflow_o); end
        iretire_i = 2'b00;
        for (int e = 1; e < 8; e++) begin
            checks++;
            if (iretire_o !== 1'b1 || iaddr_o[0] !== 32'h100 + 32'(e * 4)) begin
                failures++; $display("FAIL drain_order e=%0d act=%0b/%h exp=1/%h", e, iretire_o, iaddr_o[0], 32'h100 + 32'(e * 4));
            end
            tick();
        end
        checks++; if (count_o !== 4'd0 || iretire_o !== 1'b0) begin failures++; $display("FAIL drain_empty act=%0d/%0b exp=0/0", count_o, iretire_o); end
    endtask

    task automatic test_back_to_back;
        ready_i    = 1'b0;
        iretire_i  = 2'b01;
        iaddr_i[0] = 32'h500;
        tick();
        ready_i    = 1'b1;
        iretire_i  = 2'b11;
        iaddr_i[0] = 32'h504;
        iaddr_i[1] = 32'h508;
        tick();
        iretire_i = 2'b00;
        checks++; if (count_o !== 4'd2 || iaddr_o[0] !== 32'h504) begin failures++; $display("FAIL b2b_pushpop act=%0d/%h exp=2/504", count_o, iaddr_o[0]); end
        tick();
        checks++; if (count_o !== 4'd1 || iaddr_o[0] !== 32'h508) begin failures++; $display("FAIL b2b_next act=%0d/%h exp=1/508", count_o, iaddr_o[0]); end
        tick();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL b2b_empty act=%0d exp=0", count_o); end
    endtask

    task automatic test_latency;
        @(negedge clk_i);
        ready_i    = 1'b1;
        iretire_i  = 2'b01;
        iaddr_i[0] = 32'h3000;
        #1;
`ifdef MURE_BYPASS_EN
        checks++; if (iretire_o !== 1'b1 || iaddr_o[0] !== 32'h3000) begin failures++; $display("FAIL bypass_same act=%0b/%h exp=1/3000", iretire_o, iaddr_o[0]); end
        tick();
        iretire_i = 2'b00;
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL bypass_count act=%0d exp=0", count_o); end
`else
        checks++; if (iretire_o !== 1'b0) begin failures++; $display("FAIL nofallthru act=%0b exp=0", iretire_o); end
        tick();
        iretire_i = 2'b00;
        checks++; if (count_o !== 4'd1 || iaddr_o[0] !== 32'h3000) begin failures++; $display("FAIL latency_next act=%0d/%h exp=1/3000", count_o, iaddr_o[0]); end
        tick();
`endif
    endtask

    task automatic test_reset_clears;
        ready_i   = 1'b0;
        iretire_i = 2'b11;
        repeat (5) tick();
        iretire_i = 2'b00;
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set act=%0b exp=1", overflow_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (overflow_o !== 1'b0 || count_o !== 4'd0 || ready_o !== 1'b1) begin failures++; $display("FAIL async_reset act=%0b/%0d/%0b exp=0/0/1", overflow_o, count_o, ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_order();
        test_fields();
        test_fill_overflow();
        test_back_to_back();
        test_latency();
        test_reset_clears();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
